// File: rtl/flash_read_arbiter_if.sv
// Request/response bundle between two read masters and the flash arbiter.
// master = requester side, slave = arbiter side.
interface flash_read_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_addr;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_addr;

    logic        resp0_valid;
    logic        resp0_ready;
    logic [63:0] resp0_data;
    logic        resp0_err;
    logic        resp1_valid;
    logic        resp1_ready;
    logic [63:0] resp1_data;
    logic        resp1_err;

    modport master (
        output req0_valid,
        output req0_addr,
        input  req0_ready,
        output req1_valid,
        output req1_addr,
        input  req1_ready,
        input  resp0_valid,
        input  resp0_data,
        input  resp0_err,
        output resp0_ready,
        input  resp1_valid,
        input  resp1_data,
        input  resp1_err,
        output resp1_ready
    );

    modport slave (
        input  req0_valid,
        input  req0_addr,
        output req0_ready,
        input  req1_valid,
        input  req1_addr,
        output req1_ready,
        output resp0_valid,
        output resp0_data,
        output resp0_err,
        input  resp0_ready,
        output resp1_valid,
        output resp1_data,
        output resp1_err,
        input  resp1_ready
    );
endinterface

// File: rtl/flash_read_arbiter.sv
// Two-port round-robin arbiter for a single-outstanding 64-bit flash read.
// Bad addresses are answered with err and zero data without touching flash.
module flash_read_arbiter #(
    parameter logic [31:0] FLASH_BASE = 32'h1000_0000,
    parameter int unsigned FLASH_SIZE = 8192
) (
    input  logic                 clk,
    input  logic                 rst_n,
    flash_read_arbiter_if.slave  bus,
    output logic                 flash_ren,
    output logic [31:0]          flash_addr,
    input  logic [63:0]          flash_data
);

    localparam logic [31:0] LAST_ADDR =
        FLASH_BASE + FLASH_SIZE - 32'd8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic        last_grant;
    logic        owner;
    logic [63:0] rdata;
    logic        rerr;
    logic        rvalid0;
    logic        rvalid1;

    logic        grant;
    logic        hs;
    logic        done;
    logic [31:0] addr_sel;
    logic [31:0] offset;
    logic        addr_err;

    // With no contention the lone requester wins; otherwise alternate.
    always_comb begin
        grant = 1'b0;
        unique case (1'b1)
            bus.req0_valid && bus.req1_valid:
                grant = ~last_grant;
            !bus.req0_valid && bus.req1_valid:
                grant = 1'b1;
            default:
                grant = 1'b0;
        endcase
    end

    assign bus.req0_ready = (state == IDLE) && !grant;
    assign bus.req1_ready = (state == IDLE) && grant;

    always_comb begin
        hs       = 1'b0;
        addr_sel = bus.req0_addr;
        if (grant) begin
            addr_sel = bus.req1_addr;
        end
        if (state == IDLE) begin
            hs = grant ? bus.req1_valid : bus.req0_valid;
        end
    end

    assign offset   = addr_sel - FLASH_BASE;
    assign addr_err = (addr_sel[2:0] != 3'b000)
                   || (addr_sel < FLASH_BASE)
                   || (addr_sel > LAST_ADDR);

    always_comb begin
        done = 1'b0;
        if (state == RESP) begin
            done = owner ? (rvalid1 && bus.resp1_ready)
                         : (rvalid0 && bus.resp0_ready);
        end
    end

    assign bus.resp0_valid = rvalid0;
    assign bus.resp1_valid = rvalid1;
    assign bus.resp0_data  = rdata;
    assign bus.resp1_data  = rdata;
    assign bus.resp0_err   = rerr;
    assign bus.resp1_err   = rerr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            flash_ren  <= 1'b0;
            flash_addr <= 32'h0;
            rdata      <= 64'h0;
            rerr       <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hs) begin
                        owner      <= grant;
                        last_grant <= grant;
                        if (addr_err) begin
                            rdata   <= 64'h0;
                            rerr    <= 1'b1;
                            rvalid0 <= !grant;
                            rvalid1 <= grant;
                            state   <= RESP;
                        end else begin
                            flash_ren  <= 1'b1;
                            flash_addr <= offset;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    flash_ren <= 1'b0;
                    state     <= WAIT;
                end
                // Flash returns data the cycle after the read strobe.
                WAIT: begin
                    rdata   <= flash_data;
                    rerr    <= 1'b0;
                    rvalid0 <= !owner;
                    rvalid1 <= owner;
                    state   <= RESP;
                end
                RESP: begin
                    if (done) begin
                        rvalid0 <= 1'b0;
                        rvalid1 <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/flash_read_arbiter.md
FLASH_READ_ARBITER -- requirements
Module: flash_read_arbiter

Interface
REQ-001 SHALL have parameter FLASH_BASE, default 32'h1000_0000, system byte address of flash offset 0.
REQ-002 SHALL have parameter FLASH_SIZE, default 8192, flash size in bytes.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports reqN_valid  input  1, reqN_ready  output  1, reqN_addr  input  32 (N = 0, 1); reqN_addr is a system byte address.
REQ-006 SHALL have ports respN_valid  output  1, respN_ready  input  1, respN_data  output  64, respN_err  output  1 (N = 0, 1).
REQ-007 SHALL have ports flash_ren  output  1, flash_addr  output  32 (byte offset into flash), flash_data  input  64; flash_data is valid in the cycle after flash_ren is sampled high.

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-009 SHALL accept a request only in IDLE: reqN_ready = (state == IDLE) && grant == N; handshake = reqN_valid && reqN_ready.
REQ-010 SHALL arbitrate round-robin: if only one reqN_valid is high, grant that port; if both are high, grant the port not equal to last_grant.
REQ-011 SHALL update last_grant only on a completed request handshake.
REQ-012 SHALL on handshake latch owner, err = (addr[2:0] != 0) || addr < FLASH_BASE || addr > FLASH_BASE + FLASH_SIZE - 8, and offset = addr - FLASH_BASE (32-bit).
REQ-013 SHALL go IDLE -> ISSUE on a handshake with err = 0; IDLE -> RESP on a handshake with err = 1, setting resp data to 64'h0 and leaving flash_ren low.
REQ-014 SHALL drive flash_ren = 1 and flash_addr = latched offset in ISSUE only; flash_ren SHALL be 0 in every other state, with flash_addr holding its last value.
REQ-015 SHALL go ISSUE -> WAIT unconditionally, and WAIT -> RESP capturing flash_data into the response data register.
REQ-016 SHALL in RESP assert resp<owner>_valid with registered data/err; the other port's resp_valid SHALL stay 0.
REQ-017 SHALL hold resp data/err stable while respN_valid && !respN_ready, and go RESP -> IDLE on respN_valid && respN_ready.
REQ-018 SHALL give a valid-access latency of exactly 3 cycles from handshake edge to resp_valid high (handshake cycle T, ISSUE T+1, WAIT T+2, RESP T+3), and 1 cycle for an error access.
REQ-019 SHALL keep at most one request outstanding; both reqN_ready SHALL be 0 outside IDLE.
REQ-020 SHALL not accept a new request in the same cycle a response completes; IDLE is re-entered first.
REQ-021 SHALL accept the highest legal address FLASH_BASE + FLASH_SIZE - 8 as valid; FLASH_BASE + FLASH_SIZE SHALL be an error.
REQ-022 SHALL ignore respN_ready while respN_valid is 0.

Reset
REQ-023 SHALL on rst_n low immediately force state = IDLE, last_grant = 1, flash_ren = 0, flash_addr = 0, respN_valid = 0, respN_data = 0, respN_err = 0.
REQ-024 SHALL, on reset mid-transaction (ISSUE/WAIT/RESP), drop the in-flight response, never present it after reset, and restart with port 0 winning the first contested arbitration.

Verification
REQ-025 SHALL cover: req0 addr 32'h1000_0000, flash bytes 0..7 = 9b 02 10 00 93 92 52 02 -> flash_ren one cycle with flash_addr 0, resp0_data 64'h0252_9293_0010_029b, err 0, resp0_valid at handshake+3.
REQ-026 SHALL cover: req0 and req1 both valid continuously after reset -> grants in order 0,1,0,1; each response goes only to its owning port.
REQ-027 SHALL cover: req1 addr 32'h1000_0004 (misaligned) and 32'h1000_2000 (out of range) -> resp1_err 1, data 0, flash_ren never asserted, resp1_valid at handshake+1.
REQ-028 SHALL cover: resp0_ready held low 5 cycles in RESP -> resp0_valid/data stable throughout, req1_ready 0, completion on the first ready cycle.
REQ-029 SHALL cover: rst_n pulsed low during WAIT -> all outputs at reset values asynchronously, no resp_valid afterwards, next contested request granted to port 0.
REQ-030 SHALL cover: req0 addr 32'h1000_1FF8 -> err 0, flash_addr 32'h1FF8.
